// File: rtl/act_pack_ctrl.sv
`timescale 1ns/1ps
// act_pack_ctrl: applies ReLU/clamp/descale to the accumulator stream and packs four
// uint8 results per word into feature memory. Optional counters: ACT_PACK_STATS_EN.
module act_pack_ctrl #(
  parameter int WB_LOG2_SCALE    = 7,
  parameter int LOG2_RELU_FACTOR = 1,
  parameter int UINT_DATA_WIDTH  = 8,
  parameter int ADDR_W           = 16,
  parameter int LEN_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  output logic              busy,
  output logic              done,
  input  logic              acc_valid,
  input  logic [31:0]       acc_data,
  output logic              acc_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be,
  input  logic              wr_ready
`ifdef ACT_PACK_STATS_EN
  ,
  output logic [LEN_W-1:0]  sat_cnt,
  output logic [LEN_W-1:0]  neg_cnt
`endif
);

  localparam int LOG2_SCALE = WB_LOG2_SCALE + LOG2_RELU_FACTOR;
  localparam int CLAMP_W    = UINT_DATA_WIDTH + LOG2_SCALE;
  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CLAMP_W) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t state, state_next;

  logic [LEN_W-1:0]                      len_q, elem_cnt;
  logic [1:0]                            pack_idx;
  logic [3:0][UINT_DATA_WIDTH-1:0]       pack_q, word_next;
  logic [3:0]                            be_next;
  logic                                  is_neg, is_sat, acc_fire, wr_fire, last_elem, start_ok;
  logic [31:0]                           clamped;
  logic [UINT_DATA_WIDTH-1:0]            act_byte;

  // Negative values clamp to zero; the unsigned compare is only meaningful when non-negative.
  assign is_neg   = acc_data[31];
  assign is_sat   = !is_neg && (acc_data > MAX_VAL);
  assign clamped  = is_neg ? '0 : (is_sat ? MAX_VAL : acc_data);
  assign act_byte = clamped[LOG2_SCALE +: UINT_DATA_WIDTH];

  assign start_ok  = (state == S_IDLE) && cfg_start;
  assign wr_fire   = wr_valid && wr_ready;
  // The write register holds one word, so the stream stalls while a write is pending.
  assign acc_ready = (state == S_RUN) && (elem_cnt < len_q) && !(wr_valid && !wr_ready);
  assign acc_fire  = acc_valid && acc_ready;
  assign last_elem = (elem_cnt == len_q - 1'b1);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    word_next           = pack_q;
    word_next[pack_idx] = act_byte;
    be_next             = 4'b1111;
    case (pack_idx)
      2'd0:    be_next = 4'b0001;
      2'd1:    be_next = 4'b0011;
      2'd2:    be_next = 4'b0111;
      default: be_next = 4'b1111;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cfg_start) state_next = (cfg_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (acc_fire && last_elem) state_next = S_FLUSH;
      S_FLUSH: if (wr_fire) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      elem_cnt <= '0;
      pack_idx <= '0;
      pack_q   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_be    <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= cfg_len;
        wr_addr  <= cfg_base_addr;
        elem_cnt <= '0;
        pack_idx <= '0;
        pack_q   <= '0;
      end
      if (wr_fire) begin
        wr_valid <= 1'b0;
        wr_addr  <= wr_addr + ADDR_W'(4);
      end
      // A word completing in the same cycle as a handshake overrides the clear above.
      if (acc_fire) begin
        elem_cnt <= elem_cnt + 1'b1;
        pack_idx <= pack_idx + 1'b1;
        if (pack_idx == 2'd3 || last_elem) begin
          wr_data  <= word_next;
          wr_be    <= be_next;
          wr_valid <= 1'b1;
          pack_q   <= '0;
        end else begin
          pack_q[pack_idx] <= act_byte;
        end
      end
    end
  end

`ifdef ACT_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      sat_cnt <= '0;
      neg_cnt <= '0;
    end else if (acc_fire) begin
      if (is_sat) sat_cnt <= sat_cnt + 1'b1;
      if (is_neg) neg_cnt <= neg_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_act_pack_ctrl.sv
`timescale 1ns/1ps
// tb_act_pack_ctrl: directed stimulus with a write scoreboard drained by a monitor.
module tb_act_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_base_addr = '0;
  logic        busy, done;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_data = '0;
  logic        acc_ready;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_ready = 1'b1;
`ifdef ACT_PACK_STATS_EN
  logic [15:0] sat_cnt, neg_cnt;
`endif

  act_pack_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_base_addr(cfg_base_addr),
    .busy(busy), .done(done),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready)
`ifdef ACT_PACK_STATS_EN
    , .sat_cnt(sat_cnt), .neg_cnt(neg_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_hs_cyc = -100;
  int  done_seen = 0;
  bit  ready_seen = 0;
  bit  wvalid_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write handshake pops one expected word from the scoreboard.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (acc_ready) ready_seen = 1;
    if (wr_valid) wvalid_seen = 1;
    if (!rst && wr_valid && wr_ready) begin
      wr_t e;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h, required no write",
                 wr_addr, wr_data, wr_be);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("wr_be",   64'(wr_be),   64'(e.be));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len, input logic [15:0] base);
    cfg_len = len;
    cfg_base_addr = base;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    int n = 0;
    bit taken = 0;
    acc_valid = 1'b1;
    acc_data  = v;
    while (!taken && n < 200) begin
      @(negedge clk);
      taken = acc_ready;
      tick();
      n++;
    end
    acc_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: value 0x%0h not accepted in 200 cycles, required acceptance", v);
    end
  endtask

  task automatic wait_done(input string name, output int at);
    int n = 0;
    at = -1;
    while (at < 0 && n < 100) begin
      @(negedge clk);
      if (done) at = cyc;
      n++;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no done in 100 cycles, required a done pulse", name);
    end else begin
      @(negedge clk);
      check({name, "_done_width"}, 64'(done), 64'd0);
      check({name, "_idle_busy"}, 64'(busy), 64'd0);
    end
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, s, d0;

    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, acc_ready, wr_valid, wr_addr, wr_data, wr_be}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Mixed values: 256->1, negative->0, 0x20000 saturates->255, 0xFF->0.
    exp_q.push_back('{16'h0100, 32'h00FF0001, 4'hF});
    start(16'd4, 16'h0100);
    check("t1_busy", 64'(busy), 64'd1);
    send(32'h0000_0100); send(32'hFFFF_FF00); send(32'h0002_0000); send(32'h0000_00FF);
    wait_done("t1", at);
    check("t1_done_latency", 64'(at), 64'(last_hs_cyc + 1));

    // One full word plus a two-byte partial word.
    exp_q.push_back('{16'h0200, 32'h0A0A0A0A, 4'hF});
    exp_q.push_back('{16'h0204, 32'h00000A0A, 4'h3});
    start(16'd6, 16'h0200);
    for (int i = 0; i < 6; i++) send(32'h0000_0A00);
    wait_done("t2", at);

    // Back-pressure: first word held for 5 cycles with wr_ready low.
    exp_q.push_back('{16'h0600, 32'h04030201, 4'hF});
    exp_q.push_back('{16'h0604, 32'h08070605, 4'hF});
    wr_ready = 1'b0;
    start(16'd8, 16'h0600);
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i) << 8);
      end
      begin
        int n = 0;
        while (!wr_valid && n < 50) begin @(negedge clk); n++; end
        check("t3_wr_valid_seen", 64'(wr_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("t3_stall_acc_ready", 64'(acc_ready), 64'd0);
          check("t3_stall_word", 64'({wr_valid, wr_addr, wr_data, wr_be}),
                64'({1'b1, 16'h0600, 32'h04030201, 4'hF}));
        end
        tick();
        wr_ready = 1'b1;
      end
    join
    wait_done("t3", at);

    // Zero-length job: straight to done, no stream or write activity.
    ready_seen = 0;
    wvalid_seen = 0;
    s = cyc;
    start(16'd0, 16'h0700);
    wait_done("t4a", at);
    check("t4a_done_latency", 64'(at), 64'(s + 1));
    check("t4a_acc_ready_seen", 64'(ready_seen), 64'd0);
    check("t4a_wr_valid_seen", 64'(wvalid_seen), 64'd0);

    // A start pulse mid-job must not disturb the running configuration.
    exp_q.push_back('{16'h0800, 32'h14131211, 4'hF});
    exp_q.push_back('{16'h0804, 32'h18171615, 4'hF});
    start(16'd8, 16'h0800);
    send(32'h0000_1100); send(32'h0000_1200);
    start(16'd2, 16'h0900);
    check("t4b_busy", 64'(busy), 64'd1);
    for (int i = 3; i <= 8; i++) send(32'(i + 16) << 8);
    wait_done("t4b", at);

    // Address wrap and clamp boundaries: max positive, min negative, exactly MAX, MAX+1.
    exp_q.push_back('{16'hFFFC, 32'hFFFF00FF, 4'hF});
    exp_q.push_back('{16'h0000, 32'h00000001, 4'h1});
    start(16'd5, 16'hFFFC);
    send(32'h7FFF_FFFF); send(32'h8000_0000); send(32'h0000_FFFF); send(32'h0001_0000);
    send(32'h0000_017F);
    wait_done("t5", at);

`ifdef ACT_PACK_STATS_EN
    exp_q.push_back('{16'h0A00, 32'hFFFFFF00, 4'hF});
    start(16'd4, 16'h0A00);
    send(32'hFFFF_FFFB); send(32'd70000); send(32'd65535); send(32'd65536);
    wait_done("t6", at);
    check("t6_neg_cnt", 64'(neg_cnt), 64'd1);
    check("t6_sat_cnt", 64'(sat_cnt), 64'd2);
`endif

    // Reset after 3 of 8 accepts aborts the job without a done pulse.
    start(16'd8, 16'h0400);
    send(32'h0000_0100); send(32'h0000_0200); send(32'h0000_0300);
    d0 = done_seen;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t7_reset_outputs", 64'({busy, done, acc_ready, wr_valid, wr_addr, wr_data, wr_be}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t7_no_done", 64'(done_seen), 64'(d0));
    exp_q.push_back('{16'h0400, 32'h04030201, 4'hF});
    start(16'd4, 16'h0400);
    for (int i = 1; i <= 4; i++) send(32'(i) << 8);
    wait_done("t7", at);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
